// File: rtl/cpu_pkg.sv
// Shared types and constants for the accumulator CPU sequencer: FSM states,
// opcode classes (IR[7:5]), ALU operation codes and jump condition codes.
package cpu_pkg;

    // FETCH is encoded as zero so the reset state reads back as all-zero.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_FETCH2 = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_EXEC   = 3'd5,
        ST_JUMP   = 3'd6
    } state_e;

    // Raw opcode field values found in IR[7:5].
    localparam logic [2:0] OP_LDA   = 3'b000;
    localparam logic [2:0] OP_STA   = 3'b001;
    localparam logic [2:0] OP_ADDM  = 3'b010;
    localparam logic [2:0] OP_ANDM  = 3'b011;
    localparam logic [2:0] OP_ALU0  = 3'b100;
    localparam logic [2:0] OP_ALU1  = 3'b101;
    localparam logic [2:0] OP_JMP   = 3'b110;
    localparam logic [2:0] OP_SETDI = 3'b111;

    // Decoded instruction class; both ALU opcodes collapse into CLS_ALU.
    typedef enum logic [2:0] {
        CLS_LDA   = 3'd0,
        CLS_STA   = 3'd1,
        CLS_ADDM  = 3'd2,
        CLS_ANDM  = 3'd3,
        CLS_ALU   = 3'd4,
        CLS_JMP   = 3'd5,
        CLS_SETDI = 3'd6
    } iclass_e;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_NOT   = 3'b101;
    localparam logic [2:0] ALU_SHL   = 3'b110;
    localparam logic [2:0] ALU_PASSB = 3'b111;

    localparam logic [1:0] CC_ALWAYS = 2'b00;
    localparam logic [1:0] CC_Z      = 2'b01;
    localparam logic [1:0] CC_C      = 2'b10;
    localparam logic [1:0] CC_N      = 2'b11;

    // Evaluate the index-register condition field against the current flags.
    function automatic logic cond_true(input logic [1:0] cc, input logic z,
                                       input logic c, input logic n);
        logic t;
        case (cc)
            CC_ALWAYS: t = 1'b1;
            CC_Z:      t = z;
            CC_C:      t = c;
            default:   t = n;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/cpu_sequencer_inst_class_decode.sv
// Combinational opcode-class decoder: maps IR[7:5] to an instruction class,
// flags the two-byte instructions, and gives the ALU code used by the
// memory-operand classes in their write-back cycle.
module inst_class_decode
    import cpu_pkg::*;
(
    input  logic [2:0] op,
    output iclass_e    cls,
    output logic       two_byte,
    output logic [2:0] cls_alu
);

    // Class lookup; memory classes pick PASSB/ADD/AND for write-back.
    always_comb begin
        cls      = CLS_ALU;
        two_byte = 1'b0;
        cls_alu  = ALU_PASSB;
        case (op)
            OP_LDA:   begin cls = CLS_LDA;   two_byte = 1'b1; cls_alu = ALU_PASSB; end
            OP_STA:   begin cls = CLS_STA;   two_byte = 1'b1; cls_alu = ALU_PASSB; end
            OP_ADDM:  begin cls = CLS_ADDM;  two_byte = 1'b1; cls_alu = ALU_ADD;   end
            OP_ANDM:  begin cls = CLS_ANDM;  two_byte = 1'b1; cls_alu = ALU_AND;   end
            OP_ALU0,
            OP_ALU1:  begin cls = CLS_ALU;   two_byte = 1'b0; end
            OP_JMP:   begin cls = CLS_JMP;   two_byte = 1'b1; end
            OP_SETDI: begin cls = CLS_SETDI; two_byte = 1'b0; end
            default:  begin cls = CLS_ALU;   two_byte = 1'b0; end
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetches one/two-byte instructions,
// holds IR, and drives datapath strobes as Moore outputs of the FSM state
// and IR (qualified by the memory acks in request states).
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] inst,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    input  logic       z,
    input  logic       c,
    input  logic       n,
    input  logic [1:0] di_cc,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_ld,
    output logic       tr_hi_ld,
    output logic       tr_lo_ld,
    output logic       di_ld,
    output logic       pc_inc,
    output logic       pc_load,
    output logic [5:0] s,
    output logic [2:0] alu_cont,
    output logic       flag_ld,
    output logic       instr_done,
    output logic [2:0] state_o
);

    state_e     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    // Low until the first edge after reset release, so the fetch request
    // stays quiet while reset is asserted even though the state is FETCH.
    logic       run_q, run_d;

    iclass_e    cls;
    logic       two_byte;
    logic [2:0] cls_alu;

    // Operand fields IR[3:0] are consumed by the datapath, not here.
    logic       unused_ir_low;
    assign unused_ir_low = ^ir_q[3:0];

    inst_class_decode u_dec (
        .op       (ir_q[7:5]),
        .cls      (cls),
        .two_byte (two_byte),
        .cls_alu  (cls_alu)
    );

    // State, IR and run-enable registers; reset abandons any sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FETCH;
            ir_q    <= 8'h00;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            run_q   <= run_d;
        end
    end

    // Next-state and strobe decode; every strobe defaults low.
    always_comb begin
        state_d    = state_q;
        run_d      = 1'b1;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_ld      = 1'b0;
        tr_hi_ld   = 1'b0;
        tr_lo_ld   = 1'b0;
        di_ld      = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        s          = 6'b000000;
        alu_cont   = 3'b000;
        flag_ld    = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (run_q) begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_ld   = 1'b1;
                        pc_inc  = 1'b1;
                        state_d = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                if (two_byte) begin
                    tr_hi_ld = 1'b1;
                    state_d  = ST_FETCH2;
                end else if (cls == CLS_SETDI) begin
                    di_ld      = 1'b1;
                    instr_done = 1'b1;
                    state_d    = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_FETCH2: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    tr_lo_ld = 1'b1;
                    pc_inc   = 1'b1;
                    state_d  = (cls == CLS_JMP) ? ST_JUMP : ST_MEM;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                if (cls == CLS_STA) begin
                    dmem_we = 1'b1;
                    s[3]    = 1'b1;
                    s[0]    = 1'b1;
                end
                if (dmem_ack) begin
                    if (cls == CLS_STA) begin
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                s[1]       = 1'b1;
                s[2]       = 1'b1;
                s[5]       = 1'b1;
                flag_ld    = 1'b1;
                alu_cont   = cls_alu;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_EXEC: begin
                s[2]       = 1'b1;
                flag_ld    = 1'b1;
                alu_cont   = ir_q[6:4];
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_JUMP: begin
                s[4]       = 1'b1;
                pc_load    = cond_true(di_cc, z, c, n);
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        ir_d = ir_ld ? inst : ir_q;
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-cycle expected output vectors are
// queued when an instruction is issued and popped as each cycle is sampled.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] inst;
    logic       imem_ack, dmem_ack, z, c, n;
    logic [1:0] di_cc;
    logic       imem_req, dmem_req, dmem_we, ir_ld, tr_hi_ld, tr_lo_ld;
    logic       di_ld, pc_inc, pc_load, flag_ld, instr_done;
    logic [5:0] s;
    logic [2:0] alu_cont, state_o;

    cpu_sequencer dut (
        .clk(clk), .rst(rst), .inst(inst), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .z(z), .c(c), .n(n), .di_cc(di_cc),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_ld(ir_ld),
        .tr_hi_ld(tr_hi_ld), .tr_lo_ld(tr_lo_ld), .di_ld(di_ld), .pc_inc(pc_inc),
        .pc_load(pc_load), .s(s), .alu_cont(alu_cont), .flag_ld(flag_ld),
        .instr_done(instr_done), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Packed view of every output: {state, alu_cont, strobe mask}.
    logic [22:0] obs;
    assign obs = {state_o, alu_cont, imem_req, dmem_req, dmem_we, ir_ld, tr_hi_ld,
                  tr_lo_ld, di_ld, pc_inc, pc_load, s, flag_ld, instr_done};

    localparam logic [16:0] M_DONE  = 17'h00001;
    localparam logic [16:0] M_FLAG  = 17'h00002;
    localparam logic [16:0] M_S0    = 17'h00004;
    localparam logic [16:0] M_S1    = 17'h00008;
    localparam logic [16:0] M_S2    = 17'h00010;
    localparam logic [16:0] M_S3    = 17'h00020;
    localparam logic [16:0] M_S4    = 17'h00040;
    localparam logic [16:0] M_S5    = 17'h00080;
    localparam logic [16:0] M_PCLD  = 17'h00100;
    localparam logic [16:0] M_PCINC = 17'h00200;
    localparam logic [16:0] M_DILD  = 17'h00400;
    localparam logic [16:0] M_TRLO  = 17'h00800;
    localparam logic [16:0] M_TRHI  = 17'h01000;
    localparam logic [16:0] M_IRLD  = 17'h02000;
    localparam logic [16:0] M_DWE   = 17'h04000;
    localparam logic [16:0] M_DREQ  = 17'h08000;
    localparam logic [16:0] M_IREQ  = 17'h10000;

    logic [22:0] sb[$];
    string       sb_tag[$];
    int          checks = 0;
    int          errors = 0;
    int          pc_inc_cnt = 0;
    int          done_cnt = 0;
    int          n_instr = 0;

    task automatic push(input string tag, input state_e st, input logic [2:0] alu,
                        input logic [16:0] m);
        sb.push_back({st, alu, m});
        sb_tag.push_back(tag);
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, sample 1ns later.
    task automatic cyc(input logic [7:0] i, input logic ia, input logic da);
        logic [22:0] e;
        string       t;
        @(negedge clk);
        inst = i; imem_ack = ia; dmem_ack = da;
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_underflow observed=%h expected=queued_entry", obs);
        end else begin
            e = sb.pop_front();
            t = sb_tag.pop_front();
            chk(t, {9'd0, obs}, {9'd0, e});
        end
        if (pc_inc) pc_inc_cnt++;
        if (instr_done) done_cnt++;
    endtask

    // Two-byte memory instruction with 'waits' stall cycles before dmem_ack.
    task automatic run_mem(input string tag, input logic [7:0] b1, input logic [7:0] b2,
                           input int waits, input logic is_sta, input logic [2:0] wb_alu);
        logic [16:0] mm;
        mm = M_DREQ | (is_sta ? (M_DWE | M_S3 | M_S0) : 17'h0);
        push({tag, "_fetch"},  ST_FETCH,  3'b000, M_IREQ | M_IRLD | M_PCINC);
        push({tag, "_decode"}, ST_DECODE, 3'b000, M_TRHI);
        push({tag, "_fetch2"}, ST_FETCH2, 3'b000, M_IREQ | M_TRLO | M_PCINC);
        for (int w = 0; w < waits; w++) push({tag, "_memwait"}, ST_MEM, 3'b000, mm);
        push({tag, "_memack"}, ST_MEM, 3'b000, mm | (is_sta ? M_DONE : 17'h0));
        if (!is_sta) push({tag, "_wb"}, ST_WB, wb_alu, M_S1 | M_S2 | M_S5 | M_FLAG | M_DONE);
        n_instr++;
        cyc(b1, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        cyc(b2, 1'b1, 1'b0);
        for (int w = 0; w < waits; w++) cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b1);
        if (!is_sta) cyc(8'h00, 1'b0, 1'b0);
    endtask

    // JMP C1/23 under a given condition field and flag set.
    task automatic run_jmp(input string tag, input logic [1:0] cc, input logic fz,
                           input logic fc, input logic fn, input logic take);
        di_cc = cc; z = fz; c = fc; n = fn;
        push({tag, "_fetch"},  ST_FETCH,  3'b000, M_IREQ | M_IRLD | M_PCINC);
        push({tag, "_decode"}, ST_DECODE, 3'b000, M_TRHI);
        push({tag, "_fetch2"}, ST_FETCH2, 3'b000, M_IREQ | M_TRLO | M_PCINC);
        push({tag, "_jump"},   ST_JUMP,   3'b000, M_S4 | M_DONE | (take ? M_PCLD : 17'h0));
        n_instr++;
        cyc(8'hC1, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h23, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        int pc_before;
        rst = 1'b0; inst = 8'h00; imem_ack = 1'b0; dmem_ack = 1'b0;
        z = 1'b0; c = 1'b0; n = 1'b0; di_cc = 2'b00;

        // Reset state: everything zero, including imem_req, until an edge after release.
        repeat (2) @(negedge clk);
        #1 chk("reset_outputs", {9'd0, obs}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("release_pre_edge", {9'd0, obs}, 32'd0);

        // ALU 8'h96, zero wait; stray acks in DECODE must be ignored.
        push("alu96_fetch",  ST_FETCH,  3'b000, M_IREQ | M_IRLD | M_PCINC);
        push("alu96_decode", ST_DECODE, 3'b000, 17'h0);
        push("alu96_exec",   ST_EXEC,   3'b001, M_S2 | M_FLAG | M_DONE);
        n_instr++;
        cyc(8'h96, 1'b1, 1'b0);
        cyc(8'h00, 1'b1, 1'b1);
        cyc(8'h00, 1'b0, 1'b0);

        // Fetch stall of 4 cycles, then SETDI 8'hF8, then a fresh request.
        for (int k = 0; k < 4; k++) push("stall_fetch", ST_FETCH, 3'b000, M_IREQ);
        push("setdi_fetch",  ST_FETCH,  3'b000, M_IREQ | M_IRLD | M_PCINC);
        push("setdi_decode", ST_DECODE, 3'b000, M_DILD | M_DONE);
        push("setdi_next",   ST_FETCH,  3'b000, M_IREQ);
        n_instr++;
        for (int k = 0; k < 4; k++) cyc(8'hF8, 1'b0, 1'b0);
        cyc(8'hF8, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);

        // ALU 8'hB4: opcode 101 with alu_cont 011.
        push("aluB4_fetch",  ST_FETCH,  3'b000, M_IREQ | M_IRLD | M_PCINC);
        push("aluB4_decode", ST_DECODE, 3'b000, 17'h0);
        push("aluB4_exec",   ST_EXEC,   3'b011, M_S2 | M_FLAG | M_DONE);
        n_instr++;
        cyc(8'hB4, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);

        // LDA 05/A0 with two data wait cycles: 7 cycles, two PC increments.
        pc_before = pc_inc_cnt;
        run_mem("lda", 8'h05, 8'hA0, 2, 1'b0, 3'b111);
        chk("lda_pc_inc_count", pc_inc_cnt - pc_before, 32'd2);

        // ADDM and ANDM at zero wait: write-back ALU codes ADD and AND.
        run_mem("addm", 8'h40, 8'h00, 0, 1'b0, 3'b000);
        run_mem("andm", 8'h60, 8'h00, 0, 1'b0, 3'b010);

        // STA zero wait: done in the MEM ack cycle, no write-back.
        run_mem("sta", 8'h20, 8'h10, 0, 1'b1, 3'b000);

        // Conditional jumps.
        run_jmp("jmp_z0",   2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        run_jmp("jmp_z1",   2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
        run_jmp("jmp_c1",   2'b10, 1'b0, 1'b1, 1'b0, 1'b1);
        run_jmp("jmp_n0",   2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        run_jmp("jmp_alw",  2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

        chk("instr_done_count", done_cnt, n_instr);
        chk("sb_drained", sb.size(), 32'd0);

        // Reset asserted while STA waits in MEM: request and write drop at once.
        push("star_fetch",  ST_FETCH,  3'b000, M_IREQ | M_IRLD | M_PCINC);
        push("star_decode", ST_DECODE, 3'b000, M_TRHI);
        push("star_fetch2", ST_FETCH2, 3'b000, M_IREQ | M_TRLO | M_PCINC);
        push("star_mem1",   ST_MEM,    3'b000, M_DREQ | M_DWE | M_S3 | M_S0);
        push("star_mem2",   ST_MEM,    3'b000, M_DREQ | M_DWE | M_S3 | M_S0);
        cyc(8'h20, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h10, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        #1 rst = 1'b0;
        #1 chk("rst_mid_mem", {9'd0, obs}, 32'd0);
        @(negedge clk);
        #1 chk("rst_held", {9'd0, obs}, 32'd0);
        rst = 1'b1;
        #1 chk("rst_release_pre_edge", {9'd0, obs}, 32'd0);
        push("after_rst_fetch", ST_FETCH, 3'b000, M_IREQ);
        cyc(8'h00, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
